// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
// The master side issues req/we/addr/wdata; the slave side returns ack/rdata.
interface mem_access_stage_if #(
  parameter int DATA_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the 16-bit pipelined processor.
// Non-memory instructions pass straight to the write-back registers in one
// cycle. Loads and stores are captured, issued over a req/ack bus of variable
// latency, and the upstream pipeline is stalled until the ack arrives.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has waited
// TIMEOUT cycles without ack (mem_err pulses for one cycle).
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [REG_W-1:0]  ex_wb,
  input  logic              ex_write_reg,
  input  logic              ex_load,
  input  logic              ex_mem_write,
  input  logic              ex_for_signal,
  mem_access_stage_if.master mem,
  output logic              stall_mem,
  output logic [DATA_W-1:0] wb_result,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_write_reg,
  output logic              wb_for_signal,
  output logic              mem_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // The wait counter is 4 bits wide, so TIMEOUT must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..15");
  end

  logic [0:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_W-1:0]  hold_dest_q, hold_dest_d;
  logic              hold_wr_q, hold_wr_d;
  logic              hold_for_q, hold_for_d;
  logic [DATA_W-1:0] wb_res_q, wb_res_d;
  logic [REG_W-1:0]  wb_dest_q, wb_dest_d;
  logic              wb_wr_q, wb_wr_d;
  logic              wb_for_q, wb_for_d;

  logic memop;
  logic ack_seen;
  logic timeout_hit;

  // A load wins when both load and store are flagged.
  assign memop    = ex_load | ex_mem_write;
  assign ack_seen = mem.mem_ack & req_q;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q;

  // Count WAIT cycles without ack; the 15th such cycle (count 14) is the abort cycle.
  assign timeout_hit = (state_q == WAIT) && !ack_seen && (cnt_q == 4'(TIMEOUT - 1));

  // Counter clears whenever idle so every access starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 4'd0;
    end else if (!ack_seen) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Timeout counter and one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_hit;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // Next-state, bus capture, write-back selection and stall generation.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hold_dest_d = hold_dest_q;
    hold_wr_d   = hold_wr_q;
    hold_for_d  = hold_for_q;
    wb_res_d    = wb_res_q;
    wb_dest_d   = wb_dest_q;
    wb_wr_d     = wb_wr_q;
    wb_for_d    = wb_for_q;
    stall_mem   = 1'b0;

    case (state_q)
      IDLE: begin
        if (memop) begin
          stall_mem   = 1'b1;
          state_d     = WAIT;
          req_d       = 1'b1;
          we_d        = ~ex_load;
          addr_d      = ex_alu;
          wdata_d     = ex_data;
          hold_dest_d = ex_wb;
          hold_wr_d   = ex_write_reg;
          hold_for_d  = ex_for_signal;
          wb_wr_d     = 1'b0;
        end else begin
          wb_res_d  = ex_alu;
          wb_dest_d = ex_wb;
          wb_wr_d   = ex_write_reg;
          wb_for_d  = ex_for_signal;
        end
      end
      WAIT: begin
        if (ack_seen) begin
          // Stall drops in the ack cycle so upstream advances on this edge.
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            wb_res_d  = mem.mem_rdata;
            wb_dest_d = hold_dest_q;
            wb_wr_d   = hold_wr_q;
            wb_for_d  = hold_for_q;
          end else begin
            wb_wr_d = 1'b0;
          end
        end else if (timeout_hit) begin
          // Abandon the access; the instruction never writes back.
          state_d = IDLE;
          req_d   = 1'b0;
          wb_wr_d = 1'b0;
        end else begin
          stall_mem = 1'b1;
          wb_wr_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        wb_wr_d = 1'b0;
      end
    endcase
  end

  // State, bus and write-back registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hold_dest_q <= '0;
      hold_wr_q   <= 1'b0;
      hold_for_q  <= 1'b0;
      wb_res_q    <= '0;
      wb_dest_q   <= '0;
      wb_wr_q     <= 1'b0;
      wb_for_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hold_dest_q <= hold_dest_d;
      hold_wr_q   <= hold_wr_d;
      hold_for_q  <= hold_for_d;
      wb_res_q    <= wb_res_d;
      wb_dest_q   <= wb_dest_d;
      wb_wr_q     <= wb_wr_d;
      wb_for_q    <= wb_for_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign wb_result     = wb_res_q;
  assign wb_dest       = wb_dest_q;
  assign wb_write_reg  = wb_wr_q;
  assign wb_for_signal = wb_for_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a cycle-by-cycle vector table for the
// ALU, load, store and back-to-back paths, plus hand sequences for reset
// during an access and for the long-wait / timeout behaviour.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ex_alu = '0;
  logic [15:0] ex_data = '0;
  logic [2:0]  ex_wb = '0;
  logic        ex_write_reg = 1'b0;
  logic        ex_load = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_for_signal = 1'b0;
  logic        stall_mem;
  logic [15:0] wb_result;
  logic [2:0]  wb_dest;
  logic        wb_write_reg;
  logic        wb_for_signal;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage_if #(.DATA_W(16)) mem_if ();

  mem_access_stage #(.DATA_W(16), .REG_W(3), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_alu        (ex_alu),
    .ex_data       (ex_data),
    .ex_wb         (ex_wb),
    .ex_write_reg  (ex_write_reg),
    .ex_load       (ex_load),
    .ex_mem_write  (ex_mem_write),
    .ex_for_signal (ex_for_signal),
    .mem           (mem_if.master),
    .stall_mem     (stall_mem),
    .wb_result     (wb_result),
    .wb_dest       (wb_dest),
    .wb_write_reg  (wb_write_reg),
    .wb_for_signal (wb_for_signal),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] dat;
    logic [2:0]  wb;
    logic        wr;
    logic        ld;
    logic        st;
    logic        fw;
    logic        ack;
    logic [15:0] rd;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_res;
    logic [2:0]  e_dest;
    logic        e_wr;
    logic        e_fw;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] alu, input logic [15:0] dat, input logic [2:0] wb,
                       input logic wr, input logic ld, input logic st, input logic fw,
                       input logic ack, input logic [15:0] rd);
    ex_alu           = alu;
    ex_data          = dat;
    ex_wb            = wb;
    ex_write_reg     = wr;
    ex_load          = ld;
    ex_mem_write     = st;
    ex_for_signal    = fw;
    mem_if.mem_ack   = ack;
    mem_if.mem_rdata = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;

    //        alu      dat      wb  wr ld st fw ak rd       | st rq we addr     wdata    res      dst wr fw
    vt[0]  = '{16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 3'd3, 1'b1, 1'b1};
    vt[1]  = '{16'h5555, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5555, 3'd2, 1'b0, 1'b0};
    vt[2]  = '{16'h0040, 16'h1111, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h1111, 16'h5555, 3'd2, 1'b0, 1'b0};
    vt[3]  = '{16'h0040, 16'h1111, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h1111, 16'h5555, 3'd2, 1'b0, 1'b0};
    vt[4]  = '{16'h0040, 16'h1111, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h1111, 16'h5555, 3'd2, 1'b0, 1'b0};
    vt[5]  = '{16'h0040, 16'h1111, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h1111, 16'hBEEF, 3'd5, 1'b1, 1'b1};
    vt[6]  = '{16'h0007, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h1111, 16'h0007, 3'd1, 1'b0, 1'b0};
    vt[7]  = '{16'h0010, 16'h00AA, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h00AA, 16'h0007, 3'd1, 1'b0, 1'b0};
    vt[8]  = '{16'h0010, 16'h00AA, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h00AA, 16'h0007, 3'd1, 1'b0, 1'b0};
    vt[9]  = '{16'h0020, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0007, 3'd1, 1'b0, 1'b0};
    vt[10] = '{16'h0020, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0A0A, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0A0A, 3'd6, 1'b1, 1'b0};
    vt[11] = '{16'h0030, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0A0A, 3'd6, 1'b0, 1'b0};
    vt[12] = '{16'h0030, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0B0B, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0B0B, 3'd7, 1'b1, 1'b1};
    vt[13] = '{16'h0050, 16'h00CC, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h00CC, 16'h0B0B, 3'd7, 1'b0, 1'b1};
    vt[14] = '{16'h0050, 16'h00CC, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1357, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h00CC, 16'h1357, 3'd2, 1'b1, 1'b0};
    vt[15] = '{16'h0099, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h00CC, 16'h0099, 3'd3, 1'b1, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset req", mem_if.mem_req, 0);
    check("reset we", mem_if.mem_we, 0);
    check("reset addr", mem_if.mem_addr, 0);
    check("reset wdata", mem_if.mem_wdata, 0);
    check("reset wb_result", wb_result, 0);
    check("reset wb_dest", wb_dest, 0);
    check("reset wb_write_reg", wb_write_reg, 0);
    check("reset wb_for", wb_for_signal, 0);
    check("reset mem_err", mem_err, 0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].alu, vt[i].dat, vt[i].wb, vt[i].wr, vt[i].ld, vt[i].st, vt[i].fw, vt[i].ack, vt[i].rd);
      #1;
      check($sformatf("v%0d stall", i), stall_mem, vt[i].e_stall);
      @(posedge clk);
      #1;
      check($sformatf("v%0d req", i), mem_if.mem_req, vt[i].e_req);
      check($sformatf("v%0d we", i), mem_if.mem_we, vt[i].e_we);
      check($sformatf("v%0d addr", i), mem_if.mem_addr, vt[i].e_addr);
      check($sformatf("v%0d wdata", i), mem_if.mem_wdata, vt[i].e_wdata);
      check($sformatf("v%0d wb_result", i), wb_result, vt[i].e_res);
      check($sformatf("v%0d wb_dest", i), wb_dest, vt[i].e_dest);
      check($sformatf("v%0d wb_write_reg", i), wb_write_reg, vt[i].e_wr);
      check($sformatf("v%0d wb_for", i), wb_for_signal, vt[i].e_fw);
      check($sformatf("v%0d mem_err", i), mem_err, 0);
    end

    // Reset asserted while an access is outstanding
    @(negedge clk);
    drive(16'h0060, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    check("rstmid req before", mem_if.mem_req, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid req", mem_if.mem_req, 0);
    check("rstmid addr", mem_if.mem_addr, 0);
    check("rstmid wb_result", wb_result, 0);
    check("rstmid wb_dest", wb_dest, 0);
    check("rstmid wb_write_reg", wb_write_reg, 0);
    check("rstmid wb_for", wb_for_signal, 0);
    drive(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA);
    #1;
    check("rstmid stall", stall_mem, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("stray ack wb_write_reg", wb_write_reg, 0);
    check("stray ack req", mem_if.mem_req, 0);
    check("stray ack wb_result", wb_result, 16'h0000);

    // Long wait: aborted by timeout when enabled, otherwise held until ack
    @(negedge clk);
    drive(16'h0070, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("long capture stall", stall_mem, 1);
    @(posedge clk);
    #1;
    check("long capture req", mem_if.mem_req, 1);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("to%0d stall", i), stall_mem, (i < 14) ? 1 : 0);
      @(posedge clk);
      #1;
      check($sformatf("to%0d req", i), mem_if.mem_req, (i < 14) ? 1 : 0);
      check($sformatf("to%0d mem_err", i), mem_err, (i == 14) ? 1 : 0);
      check($sformatf("to%0d wb_write_reg", i), wb_write_reg, 0);
    end
    @(negedge clk);
    drive(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    check("to after mem_err", mem_err, 0);
    check("to after req", mem_if.mem_req, 0);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("wait%0d stall", i), stall_mem, 1);
      @(posedge clk);
      #1;
      check($sformatf("wait%0d req", i), mem_if.mem_req, 1);
      check($sformatf("wait%0d mem_err", i), mem_err, 0);
    end
    @(negedge clk);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 16'h2468;
    #1;
    check("late ack stall", stall_mem, 0);
    @(posedge clk);
    #1;
    check("late ack req", mem_if.mem_req, 0);
    check("late ack wb_result", wb_result, 16'h2468);
    check("late ack wb_dest", wb_dest, 3'd4);
    check("late ack wb_write_reg", wb_write_reg, 1);
    @(negedge clk);
    drive(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
